uart_hid_decoder: RTL and testbench

- Receives ASCII HID report lines on a UART RX pin and decodes them into the same signal set that usb_hid_host drives: type, report strobe, key, mouse and gamepad fields.
- Mirror of hid_printer, which encodes those signals onto UART TX.
- Used to inject HID traffic from a PC into cores (and benches) without a physical USB device; sits in the 12 MHz USB clock domain next to usb_hid_host.

---
 rtl/uart_hid_decoder.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_uart_hid_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hid_decoder.sv
// Decodes ASCII HID report lines ("K..", "M..", "G..") received on an 8N1 UART
// into the usb_hid_host-style report signal set.
module uart_hid_decoder #(
    parameter int CLK_FREQ = 12000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       uart_rx,
    output logic [1:0] usb_type,
    output logic       usb_report,
    output logic [7:0] key_modifiers,
    output logic [7:0] key1,
    output logic [7:0] key2,
    output logic [7:0] key3,
    output logic [7:0] key4,
    output logic [7:0] mouse_btn,
    output logic [7:0] mouse_dx,
    output logic [7:0] mouse_dy,
    output logic       game_l,
    output logic       game_r,
    output logic       game_u,
    output logic       game_d,
    output logic       game_a,
    output logic       game_b,
    output logic       game_x,
    output logic       game_y,
    output logic       game_sel,
    output logic       game_sta,
    output logic       err
);
    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

    typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rx_state_e;
    typedef enum logic [1:0] {P_IDLE = 2'd0, P_COLLECT = 2'd1, P_DISCARD = 2'd2} p_state_e;

    // Returns {valid, nibble} for an ASCII hex digit of either case.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            r = {1'b1, c[3:0] + 4'd9};
        end else begin
            r = 5'd0;
        end
        return r;
    endfunction

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            fall_s, byte_valid_s, frame_err_s;

    p_state_e        p_state_q, p_state_d;
    logic [3:0]      dig_cnt_q, dig_cnt_d, need_q, need_d;
    logic [1:0]      kind_q, kind_d;
    logic [39:0]     acc_q, acc_d;
    logic            err_s, commit_s, is_term_s;
    logic [4:0]      hex_s;

    logic [1:0]      usb_type_q;
    logic            report_q, err_q;
    logic [39:0]     key_q;
    logic [23:0]     mouse_q;
    logic [9:0]      game_q;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign fall_s = rx_prev_q & ~rx_sync_q;

    // Receiver state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= CNT_ZERO;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // Receiver next state: mid-start check, then one sample per bit period.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = CNT_ZERO;
                if (fall_s) begin
                    rx_state_d = RX_START;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Receiver outputs: byte strobe or framing error on the stop sample.
    always_comb begin
        byte_valid_s = 1'b0;
        frame_err_s  = 1'b0;
        if (rx_state_q == RX_STOP && rx_cnt_q == DIV_LAST) begin
            byte_valid_s = rx_sync_q;
            frame_err_s  = ~rx_sync_q;
        end else begin
            byte_valid_s = 1'b0;
            frame_err_s  = 1'b0;
        end
    end

    assign hex_s     = hex_decode(rx_shift_q);
    assign is_term_s = (rx_shift_q == 8'h0D) || (rx_shift_q == 8'h0A);

    // Line parser state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p_state_q <= P_IDLE;
            dig_cnt_q <= 4'd0;
            need_q    <= 4'd0;
            kind_q    <= 2'd0;
            acc_q     <= 40'd0;
        end else begin
            p_state_q <= p_state_d;
            dig_cnt_q <= dig_cnt_d;
            need_q    <= need_d;
            kind_q    <= kind_d;
            acc_q     <= acc_d;
        end
    end

    // Line parser next state, plus the commit/err strobes for this byte.
    always_comb begin
        p_state_d = p_state_q;
        dig_cnt_d = dig_cnt_q;
        need_d    = need_q;
        kind_d    = kind_q;
        acc_d     = acc_q;
        err_s     = 1'b0;
        commit_s  = 1'b0;
        if (frame_err_s) begin
            err_s     = 1'b1;
            p_state_d = P_DISCARD;
        end else if (byte_valid_s) begin
            case (p_state_q)
                P_IDLE: begin
                    dig_cnt_d = 4'd0;
                    acc_d     = 40'd0;
                    case (rx_shift_q)
                        8'h4B: begin p_state_d = P_COLLECT; need_d = 4'd10; kind_d = 2'd1; end
                        8'h4D: begin p_state_d = P_COLLECT; need_d = 4'd6;  kind_d = 2'd2; end
                        8'h47: begin p_state_d = P_COLLECT; need_d = 4'd4;  kind_d = 2'd3; end
                        8'h0D, 8'h0A: p_state_d = P_IDLE;
                        default: begin err_s = 1'b1; p_state_d = P_DISCARD; end
                    endcase
                end
                P_COLLECT: begin
                    if (is_term_s) begin
                        p_state_d = P_IDLE;
                        commit_s  = (dig_cnt_q == need_q);
                        err_s     = (dig_cnt_q != need_q);
                    end else if (hex_s[4] && dig_cnt_q != need_q) begin
                        acc_d     = {acc_q[35:0], hex_s[3:0]};
                        dig_cnt_d = dig_cnt_q + 4'd1;
                    end else begin
                        err_s     = 1'b1;
                        p_state_d = P_DISCARD;
                    end
                end
                P_DISCARD: begin
                    if (is_term_s) begin
                        p_state_d = P_IDLE;
                    end else begin
                        p_state_d = P_DISCARD;
                    end
                end
                default: p_state_d = P_IDLE;
            endcase
        end else begin
            p_state_d = p_state_q;
        end
    end

    // Registered outputs: fields of the committed type update, others hold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            usb_type_q <= 2'd0;
            report_q   <= 1'b0;
            err_q      <= 1'b0;
            key_q      <= 40'd0;
            mouse_q    <= 24'd0;
            game_q     <= 10'd0;
        end else begin
            report_q <= commit_s;
            err_q    <= err_s;
            if (commit_s) begin
                usb_type_q <= kind_q;
                case (kind_q)
                    2'd1:    key_q   <= acc_q;
                    2'd2:    mouse_q <= acc_q[23:0];
                    2'd3:    game_q  <= acc_q[9:0];
                    default: game_q  <= game_q;
                endcase
            end
        end
    end

    assign usb_type      = usb_type_q;
    assign usb_report    = report_q;
    assign err           = err_q;
    assign key_modifiers = key_q[39:32];
    assign key1          = key_q[31:24];
    assign key2          = key_q[23:16];
    assign key3          = key_q[15:8];
    assign key4          = key_q[7:0];
    assign mouse_btn     = mouse_q[23:16];
    assign mouse_dx      = mouse_q[15:8];
    assign mouse_dy      = mouse_q[7:0];
    assign game_l        = game_q[0];
    assign game_r        = game_q[1];
    assign game_u        = game_q[2];
    assign game_d        = game_q[3];
    assign game_a        = game_q[4];
    assign game_b        = game_q[5];
    assign game_x        = game_q[6];
    assign game_y        = game_q[7];
    assign game_sel      = game_q[8];
    assign game_sta      = game_q[9];
endmodule

// File: tb/tb_uart_hid_decoder.sv
// Randomized and directed bench for uart_hid_decoder with a line-level reference model.
module tb_uart_hid_decoder;
    localparam int CLK_FREQ = 12000000;
    localparam int BAUD     = 576000;
    localparam int DIV      = CLK_FREQ / BAUD;

    logic clk = 1'b0;
    logic resetn, uart_rx;
    logic [1:0] usb_type;
    logic usb_report, err;
    logic [7:0] key_modifiers, key1, key2, key3, key4, mouse_btn, mouse_dx, mouse_dy;
    logic game_l, game_r, game_u, game_d, game_a, game_b, game_x, game_y, game_sel, game_sta;

    uart_hid_decoder #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk(clk), .resetn(resetn), .uart_rx(uart_rx),
        .usb_type(usb_type), .usb_report(usb_report),
        .key_modifiers(key_modifiers), .key1(key1), .key2(key2), .key3(key3), .key4(key4),
        .mouse_btn(mouse_btn), .mouse_dx(mouse_dx), .mouse_dy(mouse_dy),
        .game_l(game_l), .game_r(game_r), .game_u(game_u), .game_d(game_d),
        .game_a(game_a), .game_b(game_b), .game_x(game_x), .game_y(game_y),
        .game_sel(game_sel), .game_sta(game_sta), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [76:0] obs_q[$];
    logic [76:0] exp_q[$];

    int        m_mode;   // 0 waiting for a type letter, 1 taking digits, 2 dropping to end of line
    int        m_need;
    logic [1:0] m_kind, m_type;
    int        nibs[$];
    logic [39:0] m_key;
    logic [23:0] m_mouse;
    logic [9:0]  m_game;

    string CR = "\015";
    string LF = "\012";

    task automatic check_eq(input string tag, input logic [76:0] got, input logic [76:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [76:0] dut_snap(input logic e);
        return {e, usb_type, key_modifiers, key1, key2, key3, key4, mouse_btn, mouse_dx, mouse_dy,
                game_sta, game_sel, game_y, game_x, game_b, game_a, game_d, game_u, game_r, game_l};
    endfunction

    function automatic logic [76:0] model_snap(input logic e);
        return {e, m_type, m_key, m_mouse, m_game};
    endfunction

    function automatic int hexval(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (b >= "a" && b <= "f") return int'(b) - 87;
        if (b >= "A" && b <= "F") return int'(b) - 55;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_type = 2'd0; m_key = 40'd0; m_mouse = 24'd0; m_game = 10'd0;
        nibs.delete();
    endtask

    task automatic model_commit();
        longint v = 0;
        foreach (nibs[i]) v = v * 16 + nibs[i];
        m_type = m_kind;
        if (m_kind == 2'd1) m_key = v[39:0];
        else if (m_kind == 2'd2) m_mouse = v[23:0];
        else m_game = v[9:0];
        exp_q.push_back(model_snap(1'b0));
    endtask

    task automatic model_byte(input logic [7:0] b, input logic bad);
        logic term = (b == 8'h0D) || (b == 8'h0A);
        int hv = hexval(b);
        if (bad) begin
            exp_q.push_back(model_snap(1'b1)); m_mode = 2;
        end else if (m_mode == 0) begin
            if (b == "K" || b == "M" || b == "G") begin
                m_mode = 1; nibs.delete();
                m_need = (b == "K") ? 10 : (b == "M") ? 6 : 4;
                m_kind = (b == "K") ? 2'd1 : (b == "M") ? 2'd2 : 2'd3;
            end else if (!term) begin
                exp_q.push_back(model_snap(1'b1)); m_mode = 2;
            end
        end else if (m_mode == 1) begin
            if (term) begin
                if (nibs.size() == m_need) model_commit();
                else exp_q.push_back(model_snap(1'b1));
                m_mode = 0;
            end else if (hv >= 0 && nibs.size() < m_need) begin
                nibs.push_back(hv);
            end else begin
                exp_q.push_back(model_snap(1'b1)); m_mode = 2;
            end
        end else if (term) begin
            m_mode = 0;
        end
    endtask

    // Record every report/err strobe as it is seen on the DUT outputs.
    always @(negedge clk) begin
        if (resetn && (usb_report || err)) begin
            obs_q.push_back(dut_snap(err));
            check_eq("report_err_exclusive", 77'(usb_report & err), 77'd0);
        end
    end

    task automatic drive_bit(input logic v);
        uart_rx = v;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(~bad);
        if (bad) begin
            uart_rx = 1'b1;
            repeat (4) @(negedge clk);
        end
        model_byte(b, bad);
    endtask

    task automatic send_str(input string s, input int bad_idx);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], i == bad_idx);
    endtask

    task automatic compare(input string tag);
        repeat (3) @(negedge clk);
        check_eq({tag, "_count"}, 77'(obs_q.size()), 77'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check_eq({tag, "_event"}, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
        check_eq({tag, "_hold"}, dut_snap(err | usb_report), model_snap(1'b0));
    endtask

    initial begin
        resetn = 1'b0;
        uart_rx = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        check_eq("reset_state", dut_snap(err), 77'd0);
        check_eq("reset_report", 77'(usb_report), 77'd0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        send_str({"K0204000000", CR}, -1);
        compare("t1_key");
        check_eq("t1_fields", {75'd0, usb_type}, 77'd1);
        check_eq("t1_mod_key1", {61'd0, key_modifiers, key1}, {61'd0, 16'h0204});

        send_str({"Mff05fb", LF}, -1);
        compare("t2_mouse");
        check_eq("t2_fields", {51'd0, usb_type, mouse_btn, mouse_dx, mouse_dy}, {51'd0, 2'd2, 24'hFF05FB});

        send_str({"G0311", CR, LF}, -1);
        compare("t3_game");
        check_eq("t3_bits", {67'd0, game_sta, game_sel, game_y, game_x, game_b, game_a, game_d, game_u, game_r, game_l},
                 {67'd0, 10'b1100010001});

        send_str({"M01020", CR, "Q12", CR, "K00000000000", CR}, -1);
        compare("t4_rejects");

        send_str({"K0204000000", CR}, 3);
        send_str({"M000101", CR}, -1);
        compare("t5_framing");

        send_str("K12", -1);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        repeat (DIV / 2) @(negedge clk);
        resetn = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        model_reset();
        repeat (3 * DIV) @(negedge clk);
        compare("t6_reset_abort");
        send_str({"G03ff", CR}, -1);
        compare("t6_after_reset");

        for (int n = 0; n < 12; n++) begin
            string s, hx;
            int t, need, cnt, r, bad;
            t = int'($urandom_range(0, 2));
            need = (t == 0) ? 10 : (t == 1) ? 6 : 4;
            r = int'($urandom_range(0, 9));
            cnt = (r == 0) ? need + 1 : (r == 1) ? need - 1 : need;
            s = (t == 0) ? "K" : (t == 1) ? "M" : "G";
            for (int i = 0; i < cnt; i++) begin
                int k = int'($urandom_range(0, 15));
                hx = ($urandom_range(0, 1) == 1) ? "0123456789abcdef" : "0123456789ABCDEF";
                s = {s, hx.substr(k, k)};
            end
            if (r == 2) s = {s, "z"};
            case ($urandom_range(0, 2))
                0: s = {s, CR};
                1: s = {s, LF};
                default: s = {s, CR, LF};
            endcase
            bad = (r == 3) ? int'($urandom_range(0, s.len() - 1)) : -1;
            send_str(s, bad);
            compare("rand_line");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
